// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU sequencer: state encoding and default widths.
package hpu_pkg;

  localparam int unsigned ITEM_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned TMO_DEF    = 32'd16777215;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GEN  = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  // A job is in flight in GEN, ARM and RUN.
  function automatic logic is_busy(input seq_state_e st);
    return (st == ST_GEN) || (st == ST_ARM) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/hpu_seq_cnt.sv
// Loadable saturating up-counter with an equality compare against a terminal value.
module hpu_seq_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over count; counting stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/hpu_seq_ctrl.sv
// Start-driven job sequencer for the HPU compute path: GEN -> ARM -> RUN -> DONE,
// with abort, watchdog timeout and sticky status toward the register bank.
module hpu_seq_ctrl
  import hpu_pkg::*;
#(
  parameter int unsigned ITEM_W     = ITEM_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TMO_CYCLES = TMO_DEF
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_clear,
  input  logic              cfg_gen_en,
  input  logic              cfg_run_en,
  input  logic [ITEM_W-1:0] cfg_item_num,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [ADDR_W-1:0] cfg_addr_j,
  input  logic              m_tvalid,
  input  logic              m_tready,
  input  logic              m_tlast,
  output logic              gen,
  output logic              run,
  output logic [ITEM_W-1:0] item_a,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic              busy,
  output logic              done,
  output logic              err_busy,
  output logic              err_tmo,
  output logic              aborted,
  output logic [CNT_W-1:0]  run_cycles,
  output logic [2:0]        state_o
);

  seq_state_e state_q, state_d;
  logic gen_q, gen_d, run_q, run_d, busy_q, busy_d;
  logic done_q, done_d, err_busy_q, err_busy_d, err_tmo_q, err_tmo_d, aborted_q, aborted_d;
  logic              run_en_q;
  logic [ITEM_W-1:0] item_num_q;
  logic [ADDR_W-1:0] addr_i_q, addr_j_q;

  logic              latch_s, item_load_s, item_en_s, item_hit_s, rc_load_s, rc_en_s, rc_hit_s;
  logic              abort_s, last_hs_s;
  logic [ITEM_W-1:0] item_cnt_s, item_last_s;
  logic [CNT_W-1:0]  rc_cnt_s;

  assign abort_s     = cfg_abort && is_busy(state_q);
  assign last_hs_s   = m_tvalid && m_tready && m_tlast;
  assign item_last_s = item_num_q - ITEM_W'(1);

  // item_a doubles as the GEN length counter; it is reloaded to 0 whenever gen falls.
  hpu_seq_cnt #(.W(ITEM_W)) u_item_cnt (
    .clk_i      (AXIS_ACLK),
    .rst_ni     (AXIS_ARESETN),
    .load_i     (item_load_s),
    .load_val_i ({ITEM_W{1'b0}}),
    .en_i       (item_en_s),
    .term_i     (item_last_s),
    .cnt_o      (item_cnt_s),
    .hit_o      (item_hit_s)
  );

  // One counter serves both run_cycles and the watchdog; hit marks the last allowed RUN cycle.
  hpu_seq_cnt #(.W(CNT_W)) u_run_cnt (
    .clk_i      (AXIS_ACLK),
    .rst_ni     (AXIS_ARESETN),
    .load_i     (rc_load_s),
    .load_val_i ({CNT_W{1'b0}}),
    .en_i       (rc_en_s),
    .term_i     (CNT_W'(TMO_CYCLES - 32'd1)),
    .cnt_o      (rc_cnt_s),
    .hit_o      (rc_hit_s)
  );

  // Next-state, output and sticky-flag logic; abort > start > clear.
  always_comb begin
    state_d     = state_q;
    gen_d       = 1'b0;
    run_d       = 1'b0;
    done_d      = done_q;
    err_busy_d  = err_busy_q;
    err_tmo_d   = err_tmo_q;
    aborted_d   = aborted_q;
    latch_s     = 1'b0;
    item_load_s = 1'b0;
    item_en_s   = 1'b0;
    rc_load_s   = 1'b0;
    rc_en_s     = 1'b0;

    if (is_busy(state_q) && !cfg_abort) begin
      if (cfg_start) begin
        err_busy_d = 1'b1;
      end else if (cfg_clear) begin
        done_d     = 1'b0;
        err_busy_d = 1'b0;
        err_tmo_d  = 1'b0;
        aborted_d  = 1'b0;
      end else begin
        err_busy_d = err_busy_q;
      end
    end else begin
      err_busy_d = err_busy_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cfg_start) begin
          latch_s     = 1'b1;
          rc_load_s   = 1'b1;
          item_load_s = 1'b1;
          done_d      = 1'b0;
          err_busy_d  = 1'b0;
          err_tmo_d   = 1'b0;
          aborted_d   = 1'b0;
          if (cfg_gen_en && (cfg_item_num != {ITEM_W{1'b0}})) begin
            state_d = ST_GEN;
            gen_d   = 1'b1;
          end else if (cfg_run_en) begin
            state_d = ST_ARM;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else if (cfg_clear) begin
          state_d    = ST_IDLE;
          done_d     = 1'b0;
          err_busy_d = 1'b0;
          err_tmo_d  = 1'b0;
          aborted_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_GEN: begin
        if (abort_s) begin
          state_d     = ST_IDLE;
          item_load_s = 1'b1;
          aborted_d   = 1'b1;
        end else if (item_hit_s) begin
          item_load_s = 1'b1;
          if (run_en_q) begin
            state_d = ST_ARM;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          item_en_s = 1'b1;
          gen_d     = 1'b1;
        end
      end
      ST_ARM: begin
        if (abort_s) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = ST_RUN;
          run_d   = 1'b1;
        end
      end
      ST_RUN: begin
        rc_en_s = 1'b1;
        if (abort_s) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (last_hs_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (rc_hit_s) begin
          state_d   = ST_IDLE;
          err_tmo_d = 1'b1;
        end else begin
          run_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = is_busy(state_d);
  end

  // State and status registers.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q    <= ST_IDLE;
      gen_q      <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_busy_q <= 1'b0;
      err_tmo_q  <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gen_q      <= gen_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_busy_q <= err_busy_d;
      err_tmo_q  <= err_tmo_d;
      aborted_q  <= aborted_d;
    end
  end

  // Job configuration, captured only when a start is accepted.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      run_en_q   <= 1'b0;
      item_num_q <= {ITEM_W{1'b0}};
      addr_i_q   <= {ADDR_W{1'b0}};
      addr_j_q   <= {ADDR_W{1'b0}};
    end else if (latch_s) begin
      run_en_q   <= cfg_run_en;
      item_num_q <= cfg_item_num;
      addr_i_q   <= cfg_addr_i;
      addr_j_q   <= cfg_addr_j;
    end
  end

  assign gen        = gen_q;
  assign run        = run_q;
  assign item_a     = item_cnt_s;
  assign addr_i     = addr_i_q;
  assign addr_j     = addr_j_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_busy   = err_busy_q;
  assign err_tmo    = err_tmo_q;
  assign aborted    = aborted_q;
  assign run_cycles = rc_cnt_s;
  assign state_o    = state_q;

endmodule

// File: tb/tb_hpu_seq_ctrl.sv
// Directed bench for hpu_seq_ctrl; a second instance with a short watchdog covers timeout.
module tb_hpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start, cfg_abort, cfg_clear, cfg_gen_en, cfg_run_en;
  logic [15:0] cfg_item_num;
  logic [19:0] cfg_addr_i, cfg_addr_j;
  logic        m_tvalid, m_tready, m_tlast;

  logic        gen, run, busy, done, err_busy, err_tmo, aborted;
  logic [15:0] item_a;
  logic [19:0] addr_i, addr_j;
  logic [31:0] run_cycles;
  logic [2:0]  state_o;

  logic        t_gen, t_run, t_busy, t_done, t_err_busy, t_err_tmo, t_aborted;
  logic [15:0] t_item_a;
  logic [19:0] t_addr_i, t_addr_j;
  logic [31:0] t_run_cycles;
  logic [2:0]  t_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;
  logic [15:0] last_item;

  always #5 clk = ~clk;

  hpu_seq_ctrl dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_clear(cfg_clear),
    .cfg_gen_en(cfg_gen_en), .cfg_run_en(cfg_run_en), .cfg_item_num(cfg_item_num),
    .cfg_addr_i(cfg_addr_i), .cfg_addr_j(cfg_addr_j),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .gen(gen), .run(run), .item_a(item_a), .addr_i(addr_i), .addr_j(addr_j),
    .busy(busy), .done(done), .err_busy(err_busy), .err_tmo(err_tmo),
    .aborted(aborted), .run_cycles(run_cycles), .state_o(state_o)
  );

  hpu_seq_ctrl #(.TMO_CYCLES(8)) dut_t (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_clear(cfg_clear),
    .cfg_gen_en(cfg_gen_en), .cfg_run_en(cfg_run_en), .cfg_item_num(cfg_item_num),
    .cfg_addr_i(cfg_addr_i), .cfg_addr_j(cfg_addr_j),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .gen(t_gen), .run(t_run), .item_a(t_item_a), .addr_i(t_addr_i), .addr_j(t_addr_j),
    .busy(t_busy), .done(t_done), .err_busy(t_err_busy), .err_tmo(t_err_tmo),
    .aborted(t_aborted), .run_cycles(t_run_cycles), .state_o(t_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic ge, input logic re, input logic [15:0] num,
                           input logic [19:0] ai, input logic [19:0] aj);
    cfg_gen_en   = ge;
    cfg_run_en   = re;
    cfg_item_num = num;
    cfg_addr_i   = ai;
    cfg_addr_j   = aj;
    cfg_start    = 1'b1;
    tick();
    cfg_start    = 1'b0;
  endtask

  task automatic set_hs(input logic v);
    m_tvalid = v;
    m_tready = v;
    m_tlast  = v;
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_clear = 1'b0;
    cfg_gen_en = 1'b0; cfg_run_en = 1'b0; cfg_item_num = 16'd0;
    cfg_addr_i = 20'd0; cfg_addr_j = 20'd0;
    set_hs(1'b0);
    #12;
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_gen_run", {30'd0, gen, run}, 32'd0);
    chk("rst_flags", {27'd0, busy, done, err_busy, err_tmo, aborted}, 32'd0);
    chk("rst_run_cycles", run_cycles, 32'd0);
    rst_n = 1'b1;
    tick();

    // Generation only, 4 items.
    start_job(1'b1, 1'b0, 16'd4, 20'd0, 20'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_gen", {31'd0, gen}, 32'd1);
      chk("t1_item_a", {16'd0, item_a}, i);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("t1_gen_fall", {31'd0, gen}, 32'd0);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    chk("t1_state", {29'd0, state_o}, 32'd4);
    chk("t1_item_zero", {16'd0, item_a}, 32'd0);

    // Generation then run, 1000 items, last handshake on RUN cycle 50.
    start_job(1'b1, 1'b1, 16'd1000, 20'd299, 20'd2);
    chk("t2_done_cleared", {31'd0, done}, 32'd0);
    cnt = 0;
    last_item = 16'd0;
    while (gen === 1'b1 && cnt < 2000) begin
      last_item = item_a;
      cnt++;
      tick();
    end
    chk("t2_gen_len", cnt, 32'd1000);
    chk("t2_last_item", {16'd0, last_item}, 32'd999);
    chk("t2_arm_state", {29'd0, state_o}, 32'd2);
    chk("t2_arm_run", {31'd0, run}, 32'd0);
    tick();
    chk("t2_run_state", {29'd0, state_o}, 32'd3);
    chk("t2_run_high", {31'd0, run}, 32'd1);
    repeat (49) tick();
    set_hs(1'b1);
    tick();
    set_hs(1'b0);
    chk("t2_run_cycles", run_cycles, 32'd50);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_run_low", {31'd0, run}, 32'd0);
    chk("t2_addr_i", {12'd0, addr_i}, 32'd299);
    chk("t2_addr_j", {12'd0, addr_j}, 32'd2);

    // Start while busy: flagged, sequence and config untouched.
    start_job(1'b1, 1'b0, 16'd6, 20'd11, 20'd3);
    for (int i = 0; i < 6; i++) begin
      chk("t3_item_a", {16'd0, item_a}, i);
      if (i == 2) begin
        cfg_start = 1'b1;
        cfg_item_num = 16'd9;
        cfg_addr_i = 20'd7;
      end
      if (i == 3) begin
        cfg_start = 1'b0;
        chk("t3_err_busy", {31'd0, err_busy}, 32'd1);
      end
      tick();
    end
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_err_busy_sticky", {31'd0, err_busy}, 32'd1);
    chk("t3_addr_i_kept", {12'd0, addr_i}, 32'd11);
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    chk("t3_clear_flags", {30'd0, done, err_busy}, 32'd0);
    chk("t3_clear_state", {29'd0, state_o}, 32'd0);

    // Abort on RUN cycle 10.
    start_job(1'b0, 1'b1, 16'd0, 20'd1, 20'd1);
    chk("t4_arm", {29'd0, state_o}, 32'd2);
    tick();
    repeat (9) tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("t4_state", {29'd0, state_o}, 32'd0);
    chk("t4_run", {31'd0, run}, 32'd0);
    chk("t4_aborted", {31'd0, aborted}, 32'd1);
    chk("t4_done", {31'd0, done}, 32'd0);

    // Abort coincident with last handshake.
    start_job(1'b0, 1'b1, 16'd0, 20'd1, 20'd1);
    chk("t4b_aborted_cleared", {31'd0, aborted}, 32'd0);
    repeat (4) tick();
    cfg_abort = 1'b1;
    set_hs(1'b1);
    tick();
    cfg_abort = 1'b0;
    set_hs(1'b0);
    chk("t4b_aborted", {31'd0, aborted}, 32'd1);
    chk("t4b_done", {31'd0, done}, 32'd0);
    chk("t4b_state", {29'd0, state_o}, 32'd0);

    // Watchdog with TMO_CYCLES=8 on the second instance.
    start_job(1'b0, 1'b1, 16'd0, 20'd1, 20'd1);
    tick();
    chk("t5_run_high", {31'd0, t_run}, 32'd1);
    cnt = 0;
    while (t_run === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("t5_run_len", cnt, 32'd8);
    chk("t5_err_tmo", {31'd0, t_err_tmo}, 32'd1);
    chk("t5_state", {29'd0, t_state}, 32'd0);
    chk("t5_done", {31'd0, t_done}, 32'd0);
    chk("t5_main_still_run", {30'd0, run, err_tmo}, 32'd2);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;

    // item_num=0 with gen_en: GEN skipped.
    start_job(1'b1, 1'b0, 16'd0, 20'd1, 20'd1);
    chk("t5b_skip_state", {29'd0, state_o}, 32'd4);
    chk("t5b_skip_gen", {31'd0, gen}, 32'd0);
    chk("t5b_skip_done", {31'd0, done}, 32'd1);

    // Asynchronous reset mid-GEN, then a fresh job.
    start_job(1'b1, 1'b0, 16'd20, 20'd5, 20'd5);
    tick();
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("t6_pre_err_busy", {31'd0, err_busy}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gen", {31'd0, gen}, 32'd0);
    chk("t6_rst_item_a", {16'd0, item_a}, 32'd0);
    chk("t6_rst_flags", {27'd0, busy, done, err_busy, err_tmo, aborted}, 32'd0);
    chk("t6_rst_state", {29'd0, state_o}, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    start_job(1'b1, 1'b0, 16'd2, 20'd0, 20'd0);
    chk("t6_restart_item0", {15'd0, gen, item_a}, 32'h10000);
    tick();
    chk("t6_restart_item1", {15'd0, gen, item_a}, 32'h10001);
    tick();
    chk("t6_restart_done", {30'd0, gen, done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
